// File: rtl/mysystem_pio_capture.sv
// mysystem_pio_capture: synchronised, debounced PIO input with edge capture, irq mask and Avalon slave
module mysystem_pio_capture #(
  parameter int DATA_WIDTH      = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);
  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_s, stable, stable_dly_q, edge_w, wdata;
  logic [DATA_WIDTH-1:0] irqmask_q, irqmask_d, edgecap_q, edgecap_d;
  logic [31:0]           readdata_d;
  logic                  irq_d, wr;
  // synchroniser chain: each bit is delayed SYNC_STAGES cycles
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign sync_s = sync_q[SYNC_STAGES-1];
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodb
      assign stable = sync_s;
    end else begin : g_db
      logic [DATA_WIDTH-1:0] stable_q, stable_d;
      logic [CW-1:0]         cnt_q [DATA_WIDTH];
      logic [CW-1:0]         cnt_d [DATA_WIDTH];
      // per bit: count consecutive disagreeing cycles, accept new value on the last one
      always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < DATA_WIDTH; i++) begin
          cnt_d[i]    = (sync_s[i] == stable_q[i] || cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt_q[i] + CW'(1);
          stable_d[i] = (sync_s[i] != stable_q[i] && cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) ? sync_s[i] : stable_q[i];
        end
      end
      // debounce state register
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          stable_q <= '0;
          for (int i = 0; i < DATA_WIDTH; i++) cnt_q[i] <= '0;
        end else begin
          stable_q <= stable_d;
          for (int i = 0; i < DATA_WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
      end
      assign stable = stable_q;
    end
  endgenerate
  assign edge_w = (EDGE_TYPE == 0) ? (stable & ~stable_dly_q) :
                  (EDGE_TYPE == 1) ? (~stable & stable_dly_q) : (stable ^ stable_dly_q);
  assign wr     = chipselect & ~write_n;
  assign wdata  = writedata[DATA_WIDTH-1:0];
  // register next state: set beats write-1-clear, reads are unqualified by chipselect
  always_comb begin
    irqmask_d  = (wr && address == 2'd1) ? wdata : irqmask_q;
    edgecap_d  = (edgecap_q & ~((wr && address == 2'd2) ? wdata : '0)) | edge_w;
    irq_d      = |(edgecap_q & irqmask_q);
    readdata_d = (address == 2'd0) ? 32'(stable) :
                 (address == 2'd1) ? 32'(irqmask_q) :
                 (address == 2'd2) ? 32'(edgecap_q) : 32'd0;
  end
  // register file, edge history, registered read data and irq
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable_dly_q <= '0;
      irqmask_q    <= '0;
      edgecap_q    <= '0;
      readdata     <= '0;
      irq          <= 1'b0;
    end else begin
      stable_dly_q <= stable;
      irqmask_q    <= irqmask_d;
      edgecap_q    <= edgecap_d;
      readdata     <= readdata_d;
      irq          <= irq_d;
    end
  end
endmodule

// File: tb/tb_mysystem_pio_capture.sv
// tb_mysystem_pio_capture: directed checks of default, no-debounce any-edge and 32-bit configurations
module tb_mysystem_pio_capture;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [7:0]  in_a = 8'd0, in_b = 8'd0;
  logic [31:0] in_c = 32'd0;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [1:0]  addr;
    logic        cs;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;
  vec_t vecs [11];

  always #5 clk = ~clk;

  mysystem_pio_capture dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a));
  mysystem_pio_capture #(.EDGE_TYPE(2), .DEBOUNCE_CYCLES(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_b), .readdata(rd_b), .irq(irq_b));
  mysystem_pio_capture #(.DATA_WIDTH(32)) dut_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_c), .readdata(rd_c), .irq(irq_c));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    steps(2);
    reset_n = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    logic seen;
    vecs[0]  = '{2'd0, 1'b0, 1'b0, 32'h0,   32'h00, 1'b0};
    vecs[1]  = '{2'd1, 1'b0, 1'b0, 32'h0,   32'h00, 1'b0};
    vecs[2]  = '{2'd2, 1'b0, 1'b0, 32'h0,   32'h00, 1'b0};
    vecs[3]  = '{2'd3, 1'b0, 1'b0, 32'h0,   32'h00, 1'b0};
    vecs[4]  = '{2'd1, 1'b1, 1'b1, 32'hA5,  32'hA5, 1'b0};
    vecs[5]  = '{2'd1, 1'b1, 1'b1, 32'h1FF, 32'hFF, 1'b0};
    vecs[6]  = '{2'd1, 1'b0, 1'b1, 32'h3C,  32'hFF, 1'b0};
    vecs[7]  = '{2'd0, 1'b1, 1'b1, 32'h55,  32'h00, 1'b0};
    vecs[8]  = '{2'd3, 1'b1, 1'b1, 32'h77,  32'h00, 1'b0};
    vecs[9]  = '{2'd2, 1'b1, 1'b1, 32'hFF,  32'h00, 1'b0};
    vecs[10] = '{2'd1, 1'b1, 1'b1, 32'h00,  32'h00, 1'b0};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      address = vecs[i].addr;
      if (vecs[i].wr) begin
        writedata  = vecs[i].wdata;
        chipselect = vecs[i].cs;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
      end
      step();
      check($sformatf("vec%0d_rd", i), rd_a, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'd0, irq_a}, {31'd0, vecs[i].exp_irq});
    end
    // rising edge on bit0: edgecapture set 19 cycles after the change, visible on readdata one later
    in_a = 8'h01;
    address = 2'd2;
    steps(19);
    check("lat_before", rd_a, 32'h0);
    step();
    check("lat_exact", rd_a, 32'h1);
    address = 2'd0;
    step();
    check("data_bit0", rd_a, 32'h01);
    // irqmask takes effect the cycle after the write, irq one cycle after that
    bus_write(2'd1, 32'h01);
    check("irq_mask_wait", {31'd0, irq_a}, 32'd0);
    step();
    check("irq_asserted", {31'd0, irq_a}, 32'd1);
    bus_write(2'd2, 32'h01);
    check("irq_hold_clr", {31'd0, irq_a}, 32'd1);
    step();
    check("irq_cleared", {31'd0, irq_a}, 32'd0);
    check("ecap_cleared", rd_a, 32'h0);
    // falling edge is ignored with rising-only capture
    in_a = 8'h00;
    steps(30);
    check("fall_ignored", rd_a, 32'h0);
    // write-1-clear in the very cycle the new edge is captured: set wins
    in_a = 8'h01;
    steps(18);
    bus_write(2'd2, 32'h01);
    step();
    check("set_wins", rd_a, 32'h1);
    check("set_wins_irq", {31'd0, irq_a}, 32'd1);
    bus_write(2'd2, 32'h01);
    step();
    check("clr_after", rd_a, 32'h0);
    // short glitch on bit3 is rejected by debounce
    bus_write(2'd1, 32'h08);
    in_a = 8'h09;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen |= irq_a;
    end
    in_a = 8'h01;
    for (int i = 0; i < 30; i++) begin
      step();
      seen |= irq_a;
    end
    address = 2'd0;
    step();
    check("glitch_data", rd_a, 32'h01);
    address = 2'd2;
    step();
    check("glitch_ecap", rd_a, 32'h0);
    check("glitch_irq", {31'd0, seen}, 32'd0);
    // no debounce, any edge: bit1 rises then falls 5 cycles later, captured both times
    do_reset();
    in_b = 8'h02;
    address = 2'd2;
    steps(3);
    check("b_lat_before", rd_b, 32'h0);
    step();
    check("b_rise", rd_b, 32'h2);
    bus_write(2'd2, 32'h02);
    in_b = 8'h00;
    step();
    check("b_cleared", rd_b, 32'h0);
    steps(3);
    check("b_fall", rd_b, 32'h2);
    // 32-bit: reset in mid-debounce discards the count, full latency from release
    do_reset();
    in_c = 32'hFFFF_FFFF;
    steps(10);
    reset_n = 1'b0;
    step();
    check("c_rst_rd", rd_c, 32'h0);
    check("c_rst_irq", {31'd0, irq_c}, 32'd0);
    reset_n = 1'b1;
    address = 2'd2;
    step();
    check("c_ecap0", rd_c, 32'h0);
    address = 2'd1;
    step();
    check("c_mask0", rd_c, 32'h0);
    address = 2'd0;
    steps(16);
    check("c_data_before", rd_c, 32'h0);
    step();
    check("c_data", rd_c, 32'hFFFF_FFFF);
    address = 2'd2;
    step();
    check("c_ecap", rd_c, 32'hFFFF_FFFF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
